// File: rtl/fma_pkg.sv
// Shared types and widths for the mulit/mulot multiplier request/response interface.
package fma_pkg;

    localparam int MUL_W  = 27;
    localparam int PROD_W = 54;

    typedef logic mtag_t;

    typedef struct packed {
        logic             en;
        logic [MUL_W-1:0] req_in_1;
        logic [MUL_W-1:0] req_in_2;
    } mulit;

    typedef struct packed {
        logic [PROD_W-1:0] out;
    } mulot;

endpackage

// File: rtl/mul_share_pipe.sv
// Product pipeline for mul_share: stage 0 registers operands/tag/valid, then LAT-2 product
// stages; the top-level output register supplies the final cycle of latency.
module mul_share_pipe
    import fma_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_vld,
    input  mtag_t             op_tag,
    input  logic [MUL_W-1:0]  op_a,
    input  logic [MUL_W-1:0]  op_b,
    output logic              res_vld,
    output mtag_t             res_tag,
    output logic [PROD_W-1:0] res_prod
);

    function automatic logic [PROD_W-1:0] umul(input logic [MUL_W-1:0] a,
                                               input logic [MUL_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    if (LAT == 1) begin : g_comb
        always_comb begin
            res_vld  = op_vld;
            res_tag  = op_tag;
            res_prod = umul(op_a, op_b);
        end
    end else begin : g_reg
        logic [MUL_W-1:0] a_p0;
        logic [MUL_W-1:0] b_p0;
        logic             vld_pn [LAT-1];
        mtag_t            tag_pn [LAT-1];

        // Stage 0 / control chain: only the valids are reset so flushed ops never surface
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < LAT-1; i++) vld_pn[i] <= 1'b0;
            end else begin
                vld_pn[0] <= op_vld;
                for (int i = 1; i < LAT-1; i++) vld_pn[i] <= vld_pn[i-1];
            end
        end

        always_ff @(posedge clk) begin
            a_p0      <= op_a;
            b_p0      <= op_b;
            tag_pn[0] <= op_tag;
            for (int i = 1; i < LAT-1; i++) tag_pn[i] <= tag_pn[i-1];
        end

        assign res_vld = vld_pn[LAT-2];
        assign res_tag = tag_pn[LAT-2];

        if (LAT == 2) begin : g_prod_comb
            assign res_prod = umul(a_p0, b_p0);
        end else begin : g_prod_reg
            logic [PROD_W-1:0] prod_pn [LAT-2];

            // Stages 1..LAT-2: product registers
            always_ff @(posedge clk) begin
                prod_pn[0] <= umul(a_p0, b_p0);
                for (int i = 1; i < LAT-2; i++) prod_pn[i] <= prod_pn[i-1];
            end

            assign res_prod = prod_pn[LAT-3];
        end
    end

endmodule

// File: rtl/mul_share.sv
// Two-port round-robin front end sharing one pipelined 27x27 multiplier.
// Optional MUL_SHARE_CNT_EN adds saturating grant/conflict counters.
module mul_share
    import fma_pkg::*;
#(
    parameter int LAT    = 3,
    parameter bit RR_RST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  mulit        muli0,
    input  mulit        muli1,
    output logic        gnt0,
    output logic        gnt1,
    output mulot        mulo0,
    output mulot        mulo1,
    output logic        vld0,
    output logic        vld1
`ifdef MUL_SHARE_CNT_EN
    ,
    output logic [31:0] op_cnt,
    output logic [15:0] cfl_cnt
`endif
);

    logic              rr;
    logic              both;
    logic              issue;
    mtag_t             tag;
    logic [MUL_W-1:0]  op_a;
    logic [MUL_W-1:0]  op_b;
    logic              res_vld;
    mtag_t             res_tag;
    logic [PROD_W-1:0] res_prod;

    always_comb begin
        both  = muli0.en & muli1.en;
        gnt0  = !reset && muli0.en && (!muli1.en || !rr);
        gnt1  = !reset && muli1.en && (!muli0.en || rr);
        issue = gnt0 | gnt1;
        tag   = gnt1;
        op_a  = gnt1 ? muli1.req_in_1 : muli0.req_in_1;
        op_b  = gnt1 ? muli1.req_in_2 : muli0.req_in_2;
    end

    // rr names the port that wins the next contended cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr <= RR_RST;
        end else if (both) begin
            rr <= ~rr;
        end
    end

    mul_share_pipe #(
        .LAT (LAT)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .op_vld   (issue),
        .op_tag   (tag),
        .op_a     (op_a),
        .op_b     (op_b),
        .res_vld  (res_vld),
        .res_tag  (res_tag),
        .res_prod (res_prod)
    );

    // Output stage: demux by tag; mulo holds between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            vld0      <= 1'b0;
            vld1      <= 1'b0;
            mulo0.out <= '0;
            mulo1.out <= '0;
        end else begin
            vld0 <= res_vld && !res_tag;
            vld1 <= res_vld && res_tag;
            if (res_vld && !res_tag) mulo0.out <= res_prod;
            if (res_vld && res_tag)  mulo1.out <= res_prod;
        end
    end

`ifdef MUL_SHARE_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] top);
        return (cnt == top) ? cnt : cnt + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            op_cnt  <= '0;
            cfl_cnt <= '0;
        end else begin
            if (issue) op_cnt  <= sat_inc(op_cnt, 32'hFFFF_FFFF);
            if (both)  cfl_cnt <= 16'(sat_inc({16'h0, cfl_cnt}, 32'h0000_FFFF));
        end
    end
`endif

endmodule

// File: tb/tb_mul_share.sv
// Directed self-checking bench for mul_share (LAT=3, RR_RST=0); counter checks build with MUL_SHARE_CNT_EN.
module tb_mul_share;
    import fma_pkg::*;

    logic clk = 1'b0;
    logic reset;
    mulit muli0, muli1;
    logic gnt0, gnt1, vld0, vld1;
    mulot mulo0, mulo1;
`ifdef MUL_SHARE_CNT_EN
    logic [31:0] op_cnt;
    logic [15:0] cfl_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mul_share #(.LAT(3), .RR_RST(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .muli0 (muli0),
        .muli1 (muli1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .mulo0 (mulo0),
        .mulo1 (mulo1),
        .vld0  (vld0),
        .vld1  (vld1)
`ifdef MUL_SHARE_CNT_EN
        ,
        .op_cnt  (op_cnt),
        .cfl_cnt (cfl_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic en, input logic [26:0] a, input logic [26:0] b);
        if (p == 0) muli0 = '{en: en, req_in_1: a, req_in_2: b};
        else        muli1 = '{en: en, req_in_1: a, req_in_2: b};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        req(0, 1'b1, 27'd3, 27'd5);
        req(1, 1'b1, 27'd1, 27'd1);
        tick();
        tick();
        chk("rst_gnt0", 64'(gnt0), 64'd0);
        chk("rst_gnt1", 64'(gnt1), 64'd0);
        chk("rst_vld0", 64'(vld0), 64'd0);
        chk("rst_vld1", 64'(vld1), 64'd0);
        chk("rst_mulo0", 64'(mulo0.out), 64'd0);
        chk("rst_mulo1", 64'(mulo1.out), 64'd0);
        req(0, 1'b0, 27'd0, 27'd0);
        req(1, 1'b0, 27'd0, 27'd0);
        reset = 1'b0;
        tick();

        // single op on port0: 3 x 5
        req(0, 1'b1, 27'd3, 27'd5);
        #1;
        chk("single_gnt0", 64'(gnt0), 64'd1);
        chk("single_gnt1", 64'(gnt1), 64'd0);
        tick();
        req(0, 1'b0, 27'd0, 27'd0);
        chk("single_vld0_t1", 64'(vld0), 64'd0);
        tick();
        chk("single_vld0_t2", 64'(vld0), 64'd0);
        tick();
        chk("single_vld0_t3", 64'(vld0), 64'd1);
        chk("single_mulo0", 64'(mulo0.out), 64'd15);
        chk("single_vld1", 64'(vld1), 64'd0);
        tick();
        chk("single_vld0_off", 64'(vld0), 64'd0);
        chk("single_hold", 64'(mulo0.out), 64'd15);

        // max operands on port1
        req(1, 1'b1, 27'h7FFFFFF, 27'h7FFFFFF);
        #1;
        chk("max_gnt1", 64'(gnt1), 64'd1);
        tick();
        req(1, 1'b0, 27'd0, 27'd0);
        tick();
        tick();
        chk("max_vld1", 64'(vld1), 64'd1);
        chk("max_mulo1", 64'(mulo1.out), 64'h3FFFFFF0000001);
        chk("max_vld0", 64'(vld0), 64'd0);

        // zero operand on port1
        req(1, 1'b1, 27'd0, 27'd12345);
        #1;
        chk("zero_gnt1", 64'(gnt1), 64'd1);
        tick();
        req(1, 1'b0, 27'd0, 27'd0);
        tick();
        tick();
        chk("zero_vld1", 64'(vld1), 64'd1);
        chk("zero_mulo1", 64'(mulo1.out), 64'd0);

        // contention right after reset: rr favours port0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req(0, 1'b1, 27'd2, 27'd2);
        req(1, 1'b1, 27'd7, 27'd7);
        #1;
        chk("cont_gnt0_t0", 64'(gnt0), 64'd1);
        chk("cont_gnt1_t0", 64'(gnt1), 64'd0);
        tick();
        req(0, 1'b0, 27'd0, 27'd0);
        #1;
        chk("cont_gnt1_t1", 64'(gnt1), 64'd1);
        chk("cont_gnt0_t1", 64'(gnt0), 64'd0);
        tick();
        req(1, 1'b0, 27'd0, 27'd0);
        tick();
        chk("cont_vld0", 64'(vld0), 64'd1);
        chk("cont_mulo0", 64'(mulo0.out), 64'd4);
        chk("cont_vld1_early", 64'(vld1), 64'd0);
        tick();
        chk("cont_vld1", 64'(vld1), 64'd1);
        chk("cont_mulo1", 64'(mulo1.out), 64'd49);
        chk("cont_vld0_off", 64'(vld0), 64'd0);

        // both held: rr now favours port1, grants alternate
        req(0, 1'b1, 27'd1, 27'd1);
        req(1, 1'b1, 27'd1, 27'd1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_gnt0", 64'(gnt0), 64'(k % 2 == 1));
            chk("alt_gnt1", 64'(gnt1), 64'(k % 2 == 0));
            tick();
        end
        req(0, 1'b0, 27'd0, 27'd0);
        req(1, 1'b0, 27'd0, 27'd0);
        for (int k = 0; k < 5; k++) tick();

        // withdrawn request: port1 loses and drops en
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req(0, 1'b1, 27'd3, 27'd3);
        req(1, 1'b1, 27'd9, 27'd9);
        #1;
        chk("wd_gnt0", 64'(gnt0), 64'd1);
        chk("wd_gnt1", 64'(gnt1), 64'd0);
        tick();
        req(0, 1'b0, 27'd0, 27'd0);
        req(1, 1'b0, 27'd0, 27'd0);
        for (int k = 0; k < 6; k++) begin
            chk("wd_vld1", 64'(vld1), 64'd0);
            chk("wd_vld0", 64'(vld0), 64'(k == 2));
            tick();
        end
        chk("wd_mulo0", 64'(mulo0.out), 64'd9);
        chk("wd_mulo1", 64'(mulo1.out), 64'd0);

        // streaming 1x1..8x8 on port0
        for (int k = 0; k < 11; k++) begin
            if (k < 8) req(0, 1'b1, 27'(k + 1), 27'(k + 1));
            else       req(0, 1'b0, 27'd0, 27'd0);
            #1;
            if (k < 8) chk("str_gnt0", 64'(gnt0), 64'd1);
            chk("str_vld0", 64'(vld0), 64'(k >= 3));
            if (k >= 3) chk("str_mulo0", 64'(mulo0.out), 64'((k - 2) * (k - 2)));
            tick();
        end
        chk("str_vld0_end", 64'(vld0), 64'd0);
        chk("str_hold", 64'(mulo0.out), 64'd64);

        // reset mid-flight
        req(0, 1'b1, 27'd6, 27'd7);
        #1;
        chk("mid_gnt0", 64'(gnt0), 64'd1);
        tick();
        req(0, 1'b0, 27'd0, 27'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_vld0_t2", 64'(vld0), 64'd0);
        chk("mid_mulo0", 64'(mulo0.out), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_vld0", 64'(vld0), 64'd0);
            chk("mid_vld1", 64'(vld1), 64'd0);
        end
        chk("mid_mulo0_end", 64'(mulo0.out), 64'd0);

`ifdef MUL_SHARE_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cnt_op_rst", 64'(op_cnt), 64'd0);
        chk("cnt_cfl_rst", 64'(cfl_cnt), 64'd0);
        req(0, 1'b1, 27'd1, 27'd2);
        req(1, 1'b1, 27'd3, 27'd4);
        for (int k = 0; k < 4; k++) tick();
        req(1, 1'b0, 27'd0, 27'd0);
        for (int k = 0; k < 2; k++) tick();
        req(0, 1'b0, 27'd0, 27'd0);
        tick();
        chk("cnt_op", 64'(op_cnt), 64'd6);
        chk("cnt_cfl", 64'(cfl_cnt), 64'd4);
        force dut.cfl_cnt = 16'hFFFF;
        #1;
        release dut.cfl_cnt;
        req(0, 1'b1, 27'd1, 27'd1);
        req(1, 1'b1, 27'd1, 27'd1);
        tick();
        req(0, 1'b0, 27'd0, 27'd0);
        req(1, 1'b0, 27'd0, 27'd0);
        tick();
        chk("cnt_cfl_sat", 64'(cfl_cnt), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
